// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: sequences NEWGAME/PLAY/NEWBALL/OVER, keeps scores,
// lives and winner, and freezes the graphics outside of active play.
module pong_game_ctrl #(
   parameter int SCORE_W      = 7,
   parameter int WIN_SCORE    = 11,
   parameter int LIVES        = 3,
   parameter int LIVES_W      = 2,
   parameter int PAUSE_FRAMES = 120
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         btn1,
   input  logic [1:0]         btn2,
   input  logic               ai_switch,
   input  logic               frame_tick,
   input  logic               hit,
   input  logic               miss_l,
   input  logic               miss_r,
   output logic [1:0]         state,
   output logic               gra_still,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [LIVES_W-1:0] balls_left,
   output logic [1:0]         winner,
   output logic               mode_solo
);

   localparam int TIMER_W = $clog2(PAUSE_FRAMES + 1);
   localparam logic [TIMER_W-1:0] PAUSE_LOAD = TIMER_W'(PAUSE_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [LIVES_W-1:0] LIVES_VAL  = LIVES_W'(LIVES);

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      NEWBALL = 2'b10,
      OVER    = 2'b11
   } state_t;

   state_t             st;
   logic [3:0]         btn_prev;
   logic [TIMER_W-1:0] timer;
   logic               btn_edge;
   logic               miss;
   logic [SCORE_W-1:0] score1_inc;
   logic [SCORE_W-1:0] score2_inc;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
   endfunction

   // Previous-button register resets to all-ones so a button held through reset is no edge
   assign btn_edge   = (|{btn1, btn2}) && (btn_prev == 4'b0000);
   assign miss       = miss_l | miss_r;
   assign score1_inc = sat_inc(score1);
   assign score2_inc = sat_inc(score2);
   assign state      = st;

   // Game sequencer with registered outputs; gra_still tracks the next state
   always_ff @(posedge clk) begin
      if (!reset) begin
         st         <= NEWGAME;
         gra_still  <= 1'b1;
         score1     <= '0;
         score2     <= '0;
         balls_left <= LIVES_VAL;
         winner     <= 2'b00;
         mode_solo  <= 1'b0;
         timer      <= '0;
         btn_prev   <= 4'b1111;
      end else begin
         btn_prev <= {btn1, btn2};
         case (st)
            NEWGAME: begin
               if (btn_edge) begin
                  st         <= PLAY;
                  gra_still  <= 1'b0;
                  score1     <= '0;
                  score2     <= '0;
                  balls_left <= LIVES_VAL;
                  winner     <= 2'b00;
                  mode_solo  <= ai_switch;
               end
            end
            PLAY: begin
               if (miss) begin
                  // A miss always freezes play and arms the pause; hit is dropped
                  timer     <= PAUSE_LOAD;
                  gra_still <= 1'b1;
                  if (mode_solo) begin
                     balls_left <= balls_left - LIVES_W'(1);
                     st         <= (balls_left == LIVES_W'(1)) ? OVER : NEWBALL;
                  end else if (miss_l && miss_r) begin
                     st <= NEWBALL;
                  end else if (miss_l) begin
                     score2 <= score2_inc;
                     if (score2_inc == WIN_VAL) begin
                        st     <= OVER;
                        winner <= 2'b10;
                     end else begin
                        st <= NEWBALL;
                     end
                  end else begin
                     score1 <= score1_inc;
                     if (score1_inc == WIN_VAL) begin
                        st     <= OVER;
                        winner <= 2'b01;
                     end else begin
                        st <= NEWBALL;
                     end
                  end
               end else if (hit && mode_solo) begin
                  score1 <= score1_inc;
               end
            end
            NEWBALL: begin
               if (timer == '0) begin
                  if (btn_edge) begin
                     st        <= PLAY;
                     gra_still <= 1'b0;
                  end
               end else if (frame_tick) begin
                  timer <= timer - TIMER_W'(1);
               end
            end
            OVER: begin
               if (timer == '0) begin
                  st        <= NEWGAME;
                  gra_still <= 1'b1;
               end else if (frame_tick) begin
                  timer <= timer - TIMER_W'(1);
               end
            end
            default: begin
               st        <= NEWGAME;
               gra_still <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Parametrised game-state controller for the pong design, sitting between the button inputs and the `pong_graph` unit. It sequences new-game, play, new-ball and game-over phases, and drives `gra_still` to freeze the graphics. It consumes `hit`/`miss` event pulses from the graphics unit and keeps scores, balls remaining and the winner. It adds a two-player versus mode and frame-timed pauses, with configurable lives, score width and win score.

## Interface
Parameters:
- `SCORE_W`, 7: score register width.
- `WIN_SCORE`, 11: versus-mode winning score. Must satisfy 1 ≤ WIN_SCORE ≤ 2^SCORE_W−1.
- `LIVES`, 3: balls per solo game. Must be ≥ 1.
- `LIVES_W`, 2: `balls_left` width. Must satisfy 2^LIVES_W−1 ≥ LIVES.
- `PAUSE_FRAMES`, 120: pause length in `frame_tick`s (2 s at 60 Hz).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `btn1` in 2: player-1 buttons, level.
- `btn2` in 2: player-2 buttons, level.
- `ai_switch` in 1: 1 = solo mode, 0 = versus mode.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `hit` in 1: one-cycle pulse, ball hit a paddle.
- `miss_l` in 1: one-cycle pulse, ball passed the left edge (player 1 side).
- `miss_r` in 1: one-cycle pulse, ball passed the right edge (player 2 side).
- `state` out 2: current phase. 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
- `gra_still` out 1: freeze ball and graphics.
- `score1` out SCORE_W: player-1 score (solo-mode score).
- `score2` out SCORE_W: player-2 score.
- `balls_left` out LIVES_W: remaining balls in solo mode.
- `winner` out 2: 00 none, 01 player 1, 10 player 2.
- `mode_solo` out 1: mode latched at game start.

## Operation
- `btn_edge` is asserted when any bit of `{btn1,btn2}` is 1 now and all bits were 0 in the previous cycle. The previous-value register is reset to all-ones, so a button held through reset is not an edge.
- NEWGAME:
  - `gra_still` = 1.
  - On `btn_edge`: go to PLAY, clear both scores, set `balls_left` = LIVES, set `winner` = 00, set `mode_solo` = `ai_switch`.
  - `ai_switch` is ignored in every other state.
- PLAY:
  - `gra_still` = 0.
  - A miss is `miss_l | miss_r`. Any miss in a cycle takes priority over `hit` in that cycle; the `hit` is ignored.
  - Solo mode, `hit`: `score1` += 1, saturating at 2^SCORE_W−1.
  - Solo mode, miss: `balls_left` −= 1. If the old value was 1, go to OVER. Otherwise go to NEWBALL.
  - Versus mode, `miss_l` only: `score2` += 1. `hit` has no effect in versus mode.
  - Versus mode, `miss_r` only: `score1` += 1.
  - Versus mode, `miss_l` and `miss_r` together: no score change, go to NEWBALL.
  - Versus mode, after a single-sided miss: if the new score equals WIN_SCORE, go to OVER and set `winner` to that player. Otherwise go to NEWBALL.
- NEWBALL:
  - `gra_still` = 1.
  - The pause timer is loaded with PAUSE_FRAMES on entry and decrements on each `frame_tick` while nonzero.
  - Transition to PLAY requires the timer to be 0 and `btn_edge`. A `btn_edge` while the timer is nonzero is discarded.
- OVER:
  - `gra_still` = 1.
  - Timer loaded on entry. When it reaches 0, go to NEWGAME automatically.
  - Scores, `balls_left` and `winner` are held, so the display keeps the result.
- `hit`/`miss` pulses in NEWGAME, NEWBALL and OVER are ignored.
- The timer is a `$clog2(PAUSE_FRAMES+1)`-bit down-counter.

## Timing
- All outputs are registered. An event sampled at edge N appears on the outputs after edge N.
- `gra_still` is decoded from the registered state, so it changes in the same cycle as `state`.
- Reset values:
  - `state` = 00, `gra_still` = 1.
  - `score1` = `score2` = 0.
  - `balls_left` = LIVES.
  - `winner` = 00, `mode_solo` = 0, timer = 0.
- Reset asserted mid-game returns every register to its reset value at the next edge. Nothing persists.
- Pause length in NEWBALL and OVER is exactly PAUSE_FRAMES `frame_tick` pulses after entry. A `frame_tick` in the entry cycle is not counted.
- A `frame_tick` coinciding with the state transition is ignored by the new state.

## Test plan
- Reset with `btn1`=01 held, then release and press again → stays NEWGAME until the second press. On that press: `state`=01, `gra_still`=0, `balls_left`=3 one cycle later.
- Solo mode: 5 `hit` pulses, then 3 misses with the NEWBALL pause plus a button press between them → `score1`=5, `balls_left` goes 2, 1, 0, `state`=11. After 120 `frame_tick`s → `state`=00, `score1` still 5.
- Solo saturation with SCORE_W=3: 9 hits → `score1`=7.
- Versus mode: 11 `miss_r` pulses, with each pause completed and a button pressed → `score1`=11, `winner`=01, `state`=11. A `miss_l` and `hit` in the same cycle → `score2`+1, hit ignored. A simultaneous `miss_l`/`miss_r` → scores unchanged, `state`=10.
- NEWBALL: button press after 119 ticks → stays 10. Press after the 120th tick → 01.
- Reset mid-PLAY with `score1`=4 → next cycle all outputs at reset values.
